// File: rtl/macro_pipe_pkg.sv
// Shared constants and helpers for macro_pipe: depth limit, lane extraction, occupancy width.
// Pure package with no logic of its own.
package macro_pipe_pkg;

  localparam int DEPTH_MAX  = 16;
  localparam int BUS_W_MAX  = 256;
  localparam int LANE_W_MAX = 32;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Lane c of a bus made of w-bit lanes, zero-extended to LANE_W_MAX.
  function automatic logic [LANE_W_MAX-1:0] lane_slice(input logic [BUS_W_MAX-1:0] bus,
                                                       input int unsigned c,
                                                       input int unsigned w);
    logic [BUS_W_MAX-1:0] sh;
    logic [BUS_W_MAX-1:0] mask;
    sh   = bus >> (c * w);
    mask = (BUS_W_MAX'(1) << w) - BUS_W_MAX'(1);
    return LANE_W_MAX'(sh & mask);
  endfunction

endpackage

// File: rtl/macro_pipe_stage.sv
// One pipeline register stage with valid bit; 1-cycle latency.
// Accepts when empty or when its own word leaves this cycle; a stalled stage holds valid and data.
module macro_pipe_stage #(
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          up_vld,
  input  logic [DW-1:0] up_dat,
  input  logic          dn_rdy,
  output logic          rdy,
  output logic          v_q,
  output logic [DW-1:0] dat_q
);

  logic          v_d;
  logic [DW-1:0] dat_d;

  always_comb begin
    rdy   = ~v_q | dn_rdy;
    v_d   = v_q;
    dat_d = dat_q;
    if (up_vld && rdy) dat_d = up_dat;
    if (flush)         v_d = 1'b0;
    else if (rdy)      v_d = up_vld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= 1'b0;
      dat_q <= '0;
    end else begin
      v_q   <= v_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/macro_pipe.sv
// DEPTH-stage valid/ready register pipeline between macros; latency DEPTH, 1 word/cycle, full stall on out_ready low.
// Define MACRO_PIPE_OCC_EN to add the registered occupancy output.
module macro_pipe
  import macro_pipe_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef MACRO_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  localparam int BW = CHANNELS * WIDTH;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic          up_vld;
    logic [BW-1:0] up_dat;
    logic          dn_rdy;
    logic          rdy;
    logic          v;
    logic [BW-1:0] dat;

    if (i == 0) begin : g_head
      // flush blocks the input handshake so the flush-cycle word is never taken.
      assign up_vld = in_valid & ~flush;
      assign up_dat = in_data;
    end else begin : g_body
      assign up_vld = g_stage[i-1].v;
      assign up_dat = g_stage[i-1].dat;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = g_stage[i+1].rdy;
    end

    macro_pipe_stage #(.DW(BW)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .up_vld (up_vld),
      .up_dat (up_dat),
      .dn_rdy (dn_rdy),
      .rdy    (rdy),
      .v_q    (v),
      .dat_q  (dat)
    );
  end

  assign in_ready  = g_stage[0].rdy & ~flush;
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].dat;

`ifdef MACRO_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;
  logic             push;
  logic             pop;

  // Tracks popcount of the valid bits as they will be after this edge.
  always_comb begin
    push  = in_valid & in_ready;
    pop   = out_valid & out_ready;
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_macro_pipe.sv
// Directed bench for macro_pipe: single-lane stream/backpressure/flush/reset and three-lane slicing.
module tb_macro_pipe;
  import macro_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  in_data1 = '0;
  logic [20:0] in_data3 = '0;
  logic        in_ready1, in_ready3;
  logic        out_valid1, out_valid3;
  logic [6:0]  out_data1;
  logic [20:0] out_data3;
`ifdef MACRO_PIPE_OCC_EN
  logic [1:0]  occ1, occ3;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  macro_pipe #(.WIDTH(7), .CHANNELS(1), .DEPTH(3)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
`ifdef MACRO_PIPE_OCC_EN
    , .occupancy(occ1)
`endif
  );

  macro_pipe #(.WIDTH(7), .CHANNELS(3), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3)
`ifdef MACRO_PIPE_OCC_EN
    , .occupancy(occ3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick; tick;
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    chk("rst_out_data1",  32'(out_data1),  32'd0);
    chk("rst_out_valid3", 32'(out_valid3), 32'd0);
    chk("rst_out_data3",  32'(out_data3),  32'd0);
`ifdef MACRO_PIPE_OCC_EN
    chk("rst_occ", 32'(occ1), 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready1), 32'd1);
    tick;

    // streaming 0x01..0x7F at full rate, 3-cycle latency, no bubbles
    out_ready = 1'b1;
    for (int k = 0; k < 132; k++) begin
      chk("a_out_valid", 32'(out_valid1), 32'(k >= 3 && k <= 129));
      if (k >= 3 && k <= 129) chk("a_out_data", 32'(out_data1), 32'(k - 2));
      in_valid = (k < 127);
      in_data1 = 7'(k + 1);
      #1;
      chk("a_in_ready", 32'(in_ready1), 32'd1);
      tick;
    end

    // backpressure: 3 accepts, then full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data1 = (k < 3) ? 7'(8'h10 + k) : 7'h13;
      #1;
      chk("b_in_ready", 32'(in_ready1), 32'(k < 3));
      tick;
    end
    chk("b_full_valid", 32'(out_valid1), 32'd1);
    chk("b_full_head",  32'(out_data1),  32'h10);
`ifdef MACRO_PIPE_OCC_EN
    chk("b_full_occ", 32'(occ1), 32'd3);
`endif
    // simultaneous pop and push on a full pipeline
    out_ready = 1'b1;
    in_data1  = 7'h13;
    #1;
    chk("c_push_pop_rdy", 32'(in_ready1), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("c_head", 32'(out_data1), 32'h11);
`ifdef MACRO_PIPE_OCC_EN
    chk("c_occ", 32'(occ1), 32'd3);
`endif
    tick;
    chk("b_drain1", 32'(out_data1), 32'h12);
    tick;
    chk("b_drain2", 32'(out_data1), 32'h13);
    tick;
    chk("b_empty", 32'(out_valid1), 32'd0);
`ifdef MACRO_PIPE_OCC_EN
    chk("b_empty_occ", 32'(occ1), 32'd0);
`endif

    // flush with two words in flight and a word offered
    in_valid = 1'b1; in_data1 = 7'h21; tick;
    in_data1 = 7'h22; tick;
    in_data1 = 7'h23; flush = 1'b1;
    #1;
    chk("f_in_ready", 32'(in_ready1), 32'd0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("f_out_valid", 32'(out_valid1), 32'd0);
`ifdef MACRO_PIPE_OCC_EN
    chk("f_occ", 32'(occ1), 32'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("f_nothing_out", 32'(out_valid1), 32'd0);
    end

    // lane independence on three channels
    in_valid = 1'b1;
    in_data3 = {7'h33, 7'h22, 7'h11}; tick;
    in_data3 = {7'h7F, 7'h00, 7'h55}; tick;
    in_valid = 1'b0; tick;
    chk("l_valid", 32'(out_valid3), 32'd1);
    chk("l_word",  32'(out_data3),  32'h0CD111);
    chk("l_lane0", lane_slice(BUS_W_MAX'(out_data3), 0, 7), 32'h11);
    chk("l_lane1", lane_slice(BUS_W_MAX'(out_data3), 1, 7), 32'h22);
    chk("l_lane2", lane_slice(BUS_W_MAX'(out_data3), 2, 7), 32'h33);
    tick;
    chk("l2_lane0", lane_slice(BUS_W_MAX'(out_data3), 0, 7), 32'h55);
    chk("l2_lane1", lane_slice(BUS_W_MAX'(out_data3), 1, 7), 32'h00);
    chk("l2_lane2", lane_slice(BUS_W_MAX'(out_data3), 2, 7), 32'h7F);
    tick;
    chk("l_drained", 32'(out_valid3), 32'd0);

    // reset for one cycle mid-stream
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data1 = 7'(8'h40 + k);
      tick;
    end
    in_valid = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("r_out_valid1", 32'(out_valid1), 32'd0);
    chk("r_out_data1",  32'(out_data1),  32'd0);
    chk("r_out_data3",  32'(out_data3),  32'd0);
`ifdef MACRO_PIPE_OCC_EN
    chk("r_occ", 32'(occ1), 32'd0);
`endif
    in_valid = 1'b1; in_data1 = 7'h50;
    #1;
    chk("r_in_ready", 32'(in_ready1), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("r_lat1", 32'(out_valid1), 32'd0);
    tick;
    chk("r_lat2", 32'(out_valid1), 32'd0);
    tick;
    chk("r_out_valid", 32'(out_valid1), 32'd1);
    chk("r_out_word",  32'(out_data1),  32'h50);
    tick;
    chk("r_done", 32'(out_valid1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/macro_pipe.md
MACRO_PIPE -- requirements
Module: macro_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 7: bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 1: independent data lanes sharing one handshake.
REQ-003 SHALL have parameter DEPTH, default 3: register stages between macro pins; legal range 1..16.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all in-flight words.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_ready  output  1  pipeline accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  1  stage DEPTH-1 holds a word.
REQ-011 SHALL have port out_ready  input  1  downstream macro accepts out_data.
REQ-012 SHALL have port out_data  output  CHANNELS*WIDTH  lane layout as in_data.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  valid-stage count; present only under MACRO_PIPE_OCC_EN.

Function
REQ-014 SHALL hold per stage i one valid bit v[i] and one CHANNELS*WIDTH data register; stage 0 faces in_*, stage DEPTH-1 drives out_*.
REQ-015 SHALL compute stage readiness rdy[i] = !v[i] | rdy[i+1], with rdy[DEPTH] = out_ready; in_ready = rdy[0] & !flush.
REQ-016 SHALL transfer on a stage when its upstream valid and rdy[i] are both high; a word moves at most one stage per cycle.
REQ-017 SHALL give latency exactly DEPTH cycles from in handshake to out_valid with out_ready held high, at 1 word/cycle throughput.
REQ-018 SHALL hold data and valid of a stalled stage unchanged; data registers load only on transfer.
REQ-019 SHALL deassert in_ready when all DEPTH stages are valid and out_ready is low (full); no word is dropped or duplicated.
REQ-020 SHALL accept a new word into a full pipeline in the same cycle out_ready is high (simultaneous pop and push).
REQ-021 SHALL keep lanes bit-independent; no lane reorders relative to another.
REQ-022 SHALL, on flush, clear every v[i] at the next edge; flush with in_valid high accepts nothing; an out handshake in the flush cycle still counts.
REQ-023 SHALL produce out_valid and out_data directly from stage DEPTH-1 flops, with no combinational path from in_* to out_*.

Reset
REQ-024 SHALL, with reset high at an edge, clear all v[i] and all data registers to 0; out_valid=0, out_data=0, occupancy=0.
REQ-025 SHALL give reset priority over flush and transfers; reset mid-stream discards all words, and in_ready reflects out_ready again from the first cycle after reset.

Configuration
REQ-026 SHALL, with MACRO_PIPE_OCC_EN defined, register occupancy = popcount(v) and update it every cycle.
REQ-027 SHALL, without MACRO_PIPE_OCC_EN, omit the occupancy port and its logic entirely; all other behaviour is identical.

Structure
REQ-028 SHALL place in package macro_pipe_pkg: a DEPTH-max constant (16), a lane slice function, and an occupancy-width function.
REQ-029 SHALL implement one stage as sub-module macro_pipe_stage (valid, data, rdy chaining), instantiated DEPTH times by generate.

Verification
REQ-030 SHALL check WIDTH=7, CHANNELS=1, DEPTH=3, out_ready=1, stream 0x01..0x7F: words appear in order at out_data 3 cycles after acceptance, no bubbles.
REQ-031 SHALL check DEPTH=3 with out_ready=0 and 5 pushes: in_ready drops after 3 accepts, occupancy=3, then out_ready=1 drains 3 words in order.
REQ-032 SHALL check full pipeline with out_ready=1 and in_valid=1 in one cycle: one pop and one push, occupancy stays 3.
REQ-033 SHALL check flush with 2 words in flight and in_valid=1: the next cycle shows out_valid=0 and occupancy=0, and the flush-cycle input is never emitted.
REQ-034 SHALL check CHANNELS=3, WIDTH=7: lanes 0x11, 0x22, 0x33 emerge unchanged in their own slices.
REQ-035 SHALL check reset asserted mid-stream for 1 cycle: out_valid=0, out_data=0, and post-reset words emerge after DEPTH cycles.
